// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared DSP constants, mixer state type and NCO increment helper
package dsp_pkg;

   localparam int PHASE_QBITS = 4;

   typedef enum logic [1:0] {S_I, S_Q, S_COS, S_SIN} upmix_state_t;

   // Truncating integer division matches rtoi() of the real-valued expression.
   function automatic int phase_inc(input int lut_abits, input int freq, input int samp_rate);
      longint num;
      num = longint'(freq) << (lut_abits + PHASE_QBITS);
      return int'(num / longint'(samp_rate));
   endfunction

endpackage

// File: rtl/sine_lut.sv
// rtl/sine_lut.sv - SineLut: full-wave sine ROM, Q1.QBITS samples, one-cycle registered read
module SineLut #(
   parameter int ABITS = 8,
   parameter int QBITS = 15
) (
   input  logic                    clk,
   input  logic [ABITS-1:0]        addr_i,
   output logic signed [QBITS:0]   data_o
);

   localparam int     DEPTH   = 1 << ABITS;
   localparam int     QDEPTH  = DEPTH / 4;
   localparam longint ONE     = 64'sd1 << 30;
   localparam longint PI_HALF = 64'sd1686629713;

   // Quarter-wave folding plus a fixed-point Taylor series keeps the table exactly symmetric.
   function automatic longint sine_entry(input int a);
      int     quad;
      int     idx;
      longint x;
      longint term;
      longint acc;
      longint mag;
      quad = a / QDEPTH;
      idx  = a % QDEPTH;
      if (quad % 2 == 1) idx = QDEPTH - idx;
      x    = PI_HALF * longint'(idx) / longint'(QDEPTH);
      term = x;
      acc  = x;
      for (int k = 1; k <= 10; k++) begin
         term = -((((term * x) / ONE) * x) / ONE) / longint'((2 * k) * (2 * k + 1));
         acc  = acc + term;
      end
      mag = (acc * ((longint'(1) << QBITS) - 1) + ONE / 2) / ONE;
      return (quad >= 2) ? -mag : mag;
   endfunction

   logic signed [QBITS:0] rom [DEPTH];

   for (genvar a = 0; a < DEPTH; a++) begin : g_rom
      localparam longint VAL = sine_entry(a);
      assign rom[a] = VAL[QBITS:0];
   end

   always_ff @(posedge clk) begin
      data_o <= rom[addr_i];
   end

endmodule

// File: rtl/iq_upmixer.sv
// rtl/iq_upmixer.sv - interleaved I/Q to real upconverter, y = I*cos - Q*sin against an internal NCO
// Optional IQ_UPMIX_SAT_EN: clamp the output instead of two's-complement wrap.
module iq_upmixer
   import dsp_pkg::*;
#(
   parameter int DW        = 16,
   parameter int SAMP_RATE = 48000,
   parameter int FREQ      = 12000,
   parameter int LUT_ABITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic signed [DW-1:0] data_i,
   input  logic                 valid_i,
   input  logic                 last_i,
   output logic                 ready_o,
   output logic signed [DW-1:0] data_o,
   output logic                 valid_o,
   output logic                 err_o
);

   localparam int             PW        = LUT_ABITS + PHASE_QBITS;
   localparam logic [PW-1:0]  PHASE_INC = PW'(phase_inc(LUT_ABITS, FREQ, SAMP_RATE));
   localparam logic [PW-1:0]  QUARTER   = PW'(1) << (PW - 2);

   upmix_state_t            state_q, state_d;
   logic [PW-1:0]           phase_q, phase_d;
   logic signed [DW-1:0]    i_q, i_d;
   logic signed [DW-1:0]    q_q, q_d;
   logic signed [2*DW-1:0]  prod_q, prod_d;
   logic signed [DW-1:0]    data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    err_q, err_d;

   logic [LUT_ABITS-1:0]    sin_addr;
   logic [LUT_ABITS-1:0]    cos_addr;
   logic [LUT_ABITS-1:0]    lut_addr;
   logic signed [DW-1:0]    lut_data;
   logic signed [2*DW:0]    q_prod;
   logic signed [2*DW:0]    diff;
   logic signed [2*DW:0]    shifted;
   logic signed [DW-1:0]    result;

   // Adding QUARTER only touches the address field, so the offset is applied there.
   assign sin_addr = phase_q[PW-1 -: LUT_ABITS];
   assign cos_addr = sin_addr + QUARTER[PW-1 -: LUT_ABITS];
   assign lut_addr = (state_q == S_COS) ? sin_addr : cos_addr;

   SineLut #(
      .ABITS (LUT_ABITS),
      .QBITS (DW - 1)
   ) u_lut (
      .clk    (clk),
      .addr_i (lut_addr),
      .data_o (lut_data)
   );

   assign q_prod  = $signed({{(DW+1){q_q[DW-1]}}, q_q}) *
                    $signed({{(DW+1){lut_data[DW-1]}}, lut_data});
   assign diff    = $signed({prod_q[2*DW-1], prod_q}) - q_prod;
   assign shifted = diff >>> (DW - 1);

`ifdef IQ_UPMIX_SAT_EN
   localparam logic signed [2*DW:0] SAT_MAX = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [2*DW:0] SAT_MIN = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};

   always_comb begin
      result = shifted[DW-1:0];
      if (shifted > SAT_MAX)
         result = SAT_MAX[DW-1:0];
      else if (shifted < SAT_MIN)
         result = SAT_MIN[DW-1:0];
   end
`else
   logic unused_hi;
   assign unused_hi = ^shifted[2*DW:DW];
   assign result    = shifted[DW-1:0];
`endif

   assign ready_o = (state_q == S_I) || (state_q == S_Q);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      i_d     = i_q;
      q_d     = q_q;
      prod_d  = prod_q;
      data_d  = data_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         S_I: begin
            if (valid_i) begin
               if (last_i) begin
                  err_d = 1'b1;
               end else begin
                  i_d     = data_i;
                  state_d = S_Q;
               end
            end
         end
         S_Q: begin
            if (valid_i) begin
               if (last_i) begin
                  q_d     = data_i;
                  state_d = S_COS;
               end else begin
                  i_d   = data_i;
                  err_d = 1'b1;
               end
            end
         end
         S_COS: begin
            err_d   = valid_i;
            prod_d  = $signed({{DW{i_q[DW-1]}}, i_q}) *
                      $signed({{DW{lut_data[DW-1]}}, lut_data});
            state_d = S_SIN;
         end
         S_SIN: begin
            err_d   = valid_i;
            data_d  = result;
            valid_d = 1'b1;
            phase_d = phase_q + PHASE_INC;
            state_d = S_I;
         end
         default: state_d = S_I;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_I;
         phase_q <= '0;
         i_q     <= '0;
         q_q     <= '0;
         prod_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         i_q     <= i_d;
         q_q     <= q_d;
         prod_q  <= prod_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_iq_upmixer.sv
// tb/tb_iq_upmixer.sv - directed self-checking bench for iq_upmixer
module tb_iq_upmixer;

   localparam int DW = 16;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic signed [DW-1:0] data_i = '0;
   logic                 valid_i = 1'b0;
   logic                 last_i = 1'b0;

   logic                 a_ready, a_valid, a_err;
   logic signed [DW-1:0] a_data;
   logic                 b_ready, b_valid, b_err;
   logic signed [DW-1:0] b_data;

   int total = 0;
   int bad   = 0;
   int a_vcnt = 0, a_ecnt = 0, a_rlow = 0;

   always #5 clk = ~clk;

   iq_upmixer #(.DW(DW), .SAMP_RATE(48000), .FREQ(12000), .LUT_ABITS(8)) dut_a (
      .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
      .ready_o(a_ready), .data_o(a_data), .valid_o(a_valid), .err_o(a_err)
   );

   iq_upmixer #(.DW(DW), .SAMP_RATE(48000), .FREQ(6000), .LUT_ABITS(8)) dut_b (
      .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
      .ready_o(b_ready), .data_o(b_data), .valid_o(b_valid), .err_o(b_err)
   );

   always @(negedge clk) begin
      if (a_valid) a_vcnt++;
      if (a_err) a_ecnt++;
      if (!a_ready) a_rlow++;
   end

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int d, input logic l);
      data_i  = d[DW-1:0];
      last_i  = l;
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      last_i  = 1'b0;
   endtask

   task automatic pair_wait(input int i, input int q, output int lat);
      put(i, 1'b0);
      put(q, 1'b1);
      lat = 1;
      while (!a_valid && lat < 8) begin
         tick();
         lat++;
      end
   endtask

   int lat, v0, e0, r0, wrap_exp;

   initial begin
      tick();
      tick();
      rst = 1'b1;
      chk("rst_ready", int'(a_ready), 1);
      chk("rst_valid", int'(a_valid), 0);
      chk("rst_err",   int'(a_err), 0);
      chk("rst_data",  int'(a_data), 0);
      chk("rst_phase", int'(dut_a.phase_q), 0);

      pair_wait(16384, 0, lat);
      chk("p1_lat",   lat, 3);
      chk("p1_data",  int'(a_data), 16383);
      chk("p1_phase", int'(dut_a.phase_q), 1024);
      tick();
      chk("p1_strobe", int'(a_valid), 0);
      chk("p1_hold",   int'(a_data), 16383);

      pair_wait(0, 8192, lat);
      chk("p2_data", int'(a_data), -8192);
      pair_wait(16384, 0, lat);
      chk("p3_lat",   lat, 3);
      chk("p3_data",  int'(a_data), -16384);
      chk("p3_phase", int'(dut_a.phase_q), 3072);

      tick();
      v0 = a_vcnt;
      put(777, 1'b1);
      chk("lastI_err", int'(a_err), 1);
      tick();
      chk("lastI_err_end", int'(a_err), 0);
      chk("lastI_phase", int'(dut_a.phase_q), 3072);
      chk("lastI_novalid", a_vcnt - v0, 0);
      pair_wait(16384, 8192, lat);
      chk("p4_data",  int'(a_data), 8191);
      chk("p4_wrap",  int'(dut_a.phase_q), 0);
      tick();
      chk("p4_vcnt", a_vcnt - v0, 1);

      v0 = a_vcnt; e0 = a_ecnt; r0 = a_rlow;
      put(5, 1'b0);
      put(8192, 1'b0);
      chk("ovr_err", int'(a_err), 1);
      data_i = '0; last_i = 1'b1; valid_i = 1'b1;
      tick();
      last_i = 1'b0;
      tick();
      tick();
      valid_i = 1'b0;
      chk("busy_valid", int'(a_valid), 1);
      chk("busy_data",  int'(a_data), 8191);
      tick();
      tick();
      chk("busy_vcnt", a_vcnt - v0, 1);
      chk("busy_ecnt", a_ecnt - e0, 3);
      chk("busy_rlow", a_rlow - r0, 2);
      chk("busy_phase", int'(dut_a.phase_q), 1024);

      v0 = a_vcnt;
      put(1000, 1'b0);
      put(2000, 1'b1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      chk("mrst_novalid", a_vcnt - v0, 0);
      chk("mrst_data",  int'(a_data), 0);
      chk("mrst_phase", int'(dut_a.phase_q), 0);
      chk("mrst_ready", int'(a_ready), 1);
      pair_wait(16384, 8192, lat);
      chk("mrst_lat",  lat, 3);
      chk("mrst_pair", int'(a_data), 16383);

      rst = 1'b0;
      tick();
      rst = 1'b1;
      pair_wait(0, 0, lat);
      chk("sat_dummy", int'(b_data), 0);
      chk("sat_phase", int'(dut_b.phase_q), 512);
      pair_wait(-32768, 32767, lat);
`ifdef IQ_UPMIX_SAT_EN
      wrap_exp = -32768;
`else
      wrap_exp = 19196;
`endif
      chk("sat_valid", int'(b_valid), 1);
      chk("sat_data",  int'(b_data), wrap_exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/iq_upmixer.md
# iq_upmixer

Transmit-side counterpart of the receive mixer. It consumes an interleaved complex stream where each pair is an I word followed by a Q word, with `last` marking the Q word. For each pair it computes the real upconverted sample y = I·cos(φ) − Q·sin(φ) against an internal NCO and emits one real sample. It sits between the complex baseband source and the real-valued DAC-side stream.

## Interface
- `DW`, 16: sample width. Input and output are signed two's complement; LUT samples are Q1.(DW-1).
- `SAMP_RATE`, 48000: pair rate in Hz, used only for phase-increment computation.
- `FREQ`, 12000: carrier frequency in Hz.
- `LUT_ABITS`, 8: sine LUT address bits.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset. Synchronous, active-low.
- `data_i`  in  DW  signed interleaved I/Q word.
- `valid_i`  in  1  `data_i` is valid this cycle.
- `last_i`  in  1  high on the Q word of a pair, low on the I word.
- `ready_o`  out  1  high when the block can accept a word.
- `data_o`  out  DW  signed upconverted real sample.
- `valid_o`  out  1  one-cycle strobe; `data_o` is valid.
- `err_o`  out  1  one-cycle strobe; an input word was dropped.

## Operation
- Phase accumulator `phase_reg` is LUT_ABITS+PHASE_QBITS bits wide and wraps modulo 2^width.
- PHASE_INC = rtoi(2^LUT_ABITS · FREQ/SAMP_RATE · 2^PHASE_QBITS).
- QUARTER = 2^width/4.
- LUT address is taken from the top LUT_ABITS bits of the selected phase.
- Cos uses phase_reg + QUARTER; sin uses phase_reg.

States:
- S_I: `ready_o`=1.
  - valid_i & !last_i: capture I, go to S_Q.
  - valid_i & last_i: drop the word, pulse err_o, stay in S_I.
- S_Q: `ready_o`=1; LUT address = cos phase.
  - valid_i & last_i: capture Q, go to S_COS.
  - valid_i & !last_i: overwrite I with the new word, pulse err_o, stay in S_Q.
- S_COS: `ready_o`=0. LUT output is cos. Register prod_i = I·cos (2·DW bits). LUT address = sin phase.
- S_SIN: `ready_o`=0. LUT output is sin.
  - diff = prod_i − Q·sin (2·DW+1 bits).
  - data_o ← diff >>> (DW−1), reduced to DW bits per Configuration.
  - Set valid_o; phase_reg += PHASE_INC; go to S_I.
- Any valid_i while `ready_o`=0: the word is dropped and err_o pulses. The block has no back-pressure beyond `ready_o`.
- Shift is arithmetic, so results round toward −∞.
- `phase_reg` advances exactly once per emitted sample. Dropped or erroneous words never advance it.

## Timing
- Reset (rst=0 at a clk edge): state=S_I, phase_reg=0, I/Q regs=0, prod_i=0, data_o=0, valid_o=0, err_o=0, `ready_o`=1 in the following cycle.
- Reset mid-pair or mid-compute: the pending pair is discarded and no valid_o is produced.
- LUT read latency is 1 cycle: address presented in cycle t, sample available in t+1.
- Q accepted in cycle T (S_Q). S_COS is T+1, S_SIN is T+2. In T+3, valid_o=1 for one cycle with data_o, state=S_I and `ready_o`=1.
- An I word may be accepted in T+3 concurrently with valid_o.
- Throughput is one pair per 4 cycles minimum (I at T−1, Q at T, next I at T+3, next Q at T+4).
- data_o holds its value after the valid_o strobe until the next result.
- err_o is registered: it is high in the cycle after the offending word.

## Configuration
- `IQ_UPMIX_SAT_EN` defined: the shifted result is clamped to [−2^(DW−1), 2^(DW−1)−1].
- `IQ_UPMIX_SAT_EN` undefined: the DW LSBs of the shifted result are taken (two's-complement wrap).
- All other behaviour is identical either way.

## Structure
- Shared package `dsp_pkg`:
  - PHASE_QBITS (=4).
  - Enum `upmix_state_t {S_I, S_Q, S_COS, S_SIN}`.
  - Function `phase_inc(lut_abits, freq, samp_rate)` returning PHASE_INC, reused by the receive mixer.
- Sub-module: the existing `SineLut` (ABITS=LUT_ABITS, QBITS=DW−1, registered read), instantiated once and time-shared between cos and sin.
- The phase accumulator and the saturation logic stay inline.

## Test plan
All cases use DW=16 and LUT_ABITS=8 (phase width 12) unless noted.
- FREQ=SAMP_RATE/4 (PHASE_INC=1024), from reset, pair I=16384, Q=0 → valid_o 3 cycles after the Q word, data_o=16383, phase_reg=1024.
- Same configuration, second pair I=0, Q=8192 (sin=32767) → data_o=−8192. Third pair I=16384, Q=0 at phase 2048 → data_o=−16384.
- With `IQ_UPMIX_SAT_EN`, FREQ=SAMP_RATE/8, send a dummy pair, then I=−32768, Q=32767 at phase 512 → data_o=−32768.
  - Without the macro, the same stimulus → data_o equals the wrapped 16 LSBs of the golden-model result.
- Word with last_i=1 sent in S_I → err_o pulses, no valid_o, phase_reg unchanged. A following proper pair → normal output.
- Q accepted, then valid_i held high during S_COS/S_SIN → two err_o pulses, exactly one valid_o, `ready_o` low for exactly 2 cycles.
- rst=0 asserted in S_COS → no valid_o. After release, data_o=0, phase_reg=0, `ready_o`=1; the next pair processes at phase 0.
